// File: rtl/gesummv_result_drain.sv
// Ping-pong capture of the gesummv y-vector write port, drained in index order
// over valid/ready with an end-of-vector marker, a done pulse and a running checksum.
module gesummv_result_drain #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic              in_wr_en,
  input  logic [DATA_W-1:0] in_wr_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_idx,
  output logic              out_last,
  output logic              done,
  output logic [DATA_W-1:0] checksum,
  output logic              err_dup,
  output logic              err_addr,
  output logic              err_ovf
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [DEPTH-1:0] ALL_FILLED = '1;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic {IDLE, DRAIN} state_t;

  function automatic logic [DATA_W-1:0] wrap_add(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    return a + b;
  endfunction

  logic [DATA_W-1:0]       bank_mem [2][DEPTH];
  logic [1:0][DEPTH-1:0]   mask;
  logic [1:0]              full;
  logic                    fill_sel;
  logic                    drain_sel;
  logic [ADDR_W-1:0]       rd_idx;
  logic [DATA_W-1:0]       acc;
  state_t                  state;

  logic                    addr_ok;
  logic [IDX_W-1:0]        wr_idx;
  logic                    wr_ok;
  logic [DEPTH-1:0]        fill_mask_nxt;
  logic                    hs;
  logic                    last_hs;

  assign drain_sel     = ~fill_sel;
  assign addr_ok       = (32'(in_addr) < 32'(DEPTH));
  assign wr_idx        = in_addr[IDX_W-1:0];
  assign wr_ok         = in_wr_en && addr_ok && !full[fill_sel];
  assign fill_mask_nxt = mask[fill_sel] | (DEPTH'(1) << wr_idx);
  assign hs            = out_valid && out_ready;
  assign last_hs       = hs && (rd_idx == LAST_IDX);

  // The drain bank is never the write target, so its words are stable while stalled.
  assign out_data = bank_mem[drain_sel][rd_idx[IDX_W-1:0]];
  assign out_idx  = rd_idx;
  assign out_last = out_valid && (rd_idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      bank_mem[fill_sel][wr_idx] <= in_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      done      <= 1'b0;
      checksum  <= '0;
      err_dup   <= 1'b0;
      err_addr  <= 1'b0;
      err_ovf   <= 1'b0;
      mask      <= '0;
      full      <= '0;
      fill_sel  <= 1'b0;
      rd_idx    <= '0;
      acc       <= '0;
    end else begin
      done <= 1'b0;

      if (in_wr_en) begin
        if (!addr_ok) begin
          err_addr <= 1'b1;
        end else if (full[fill_sel]) begin
          err_ovf <= 1'b1;
        end else begin
          if (mask[fill_sel][wr_idx]) err_dup <= 1'b1;
          mask[fill_sel] <= fill_mask_nxt;
          if (fill_mask_nxt == ALL_FILLED) full[fill_sel] <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (full[fill_sel]) begin
            fill_sel  <= ~fill_sel;
            state     <= DRAIN;
            rd_idx    <= '0;
            out_valid <= 1'b1;
          end
        end
        DRAIN: begin
          if (hs) begin
            acc    <= wrap_add(acc, out_data);
            rd_idx <= rd_idx + 1'b1;
          end
          if (last_hs) begin
            mask[drain_sel] <= '0;
            full[drain_sel] <= 1'b0;
            done            <= 1'b1;
            checksum        <= wrap_add(acc, out_data);
            acc             <= '0;
            rd_idx          <= '0;
            // A waiting full bank is swapped in on the same edge: no bubble.
            if (full[fill_sel]) begin
              fill_sel <= ~fill_sel;
            end else begin
              state     <= IDLE;
              out_valid <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gesummv_result_drain.sv
// Bench for gesummv_result_drain: directed scenarios plus randomized fills and
// backpressure, scored against a vector-level reference model.
module tb_gesummv_result_drain;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 32;
  localparam int VEC_W  = DEPTH * DATA_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [ADDR_W-1:0] in_addr = '0;
  logic              in_wr_en = 1'b0;
  logic [DATA_W-1:0] in_wr_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_idx;
  logic              out_last;
  logic              done;
  logic [DATA_W-1:0] checksum;
  logic              err_dup;
  logic              err_addr;
  logic              err_ovf;

  gesummv_result_drain #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .in_addr(in_addr), .in_wr_en(in_wr_en),
    .in_wr_data(in_wr_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx), .out_last(out_last), .done(done),
    .checksum(checksum), .err_dup(err_dup), .err_addr(err_addr), .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: completed vectors awaiting drain, plus the partially filled one.
  logic [VEC_W-1:0] exp_q[$];
  logic [VEC_W-1:0] cur_vec = '0;
  logic [DEPTH-1:0] cur_mask = '0;
  logic exp_dup = 0, exp_addr = 0, exp_ovf = 0;
  int   pos = 0;
  logic [DATA_W-1:0] run_sum = '0;
  logic [DATA_W-1:0] exp_sum = '0;
  logic pend_done = 0, bubble_pend = 0, chk_bubble = 0;
  int   hs_cnt = 0;
  logic prev_v = 0, prev_r = 0;
  logic [DATA_W-1:0] prev_d = '0;
  logic [ADDR_W-1:0] prev_i = '0;
  int   rmode = 0;

  initial begin
    forever begin
      @(posedge clk); #1;
      case (rmode)
        0: out_ready = 1'b1;
        1: out_ready = ~out_ready;
        2: out_ready = ($urandom_range(0, 2) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      pos = 0; run_sum = '0; prev_v = 0; pend_done = 0; bubble_pend = 0;
    end else begin
      if (prev_v && !prev_r) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", out_data, prev_d);
        chk("hold_idx", 32'(out_idx), 32'(prev_i));
      end
      if (bubble_pend) begin
        chk("no_bubble", 32'(out_valid), 32'd1);
        bubble_pend = 0;
      end
      if (pend_done) begin
        chk("done_pulse", 32'(done), 32'd1);
        chk("checksum", checksum, exp_sum);
        pend_done = 0;
      end else begin
        chk("done_idle", 32'(done), 32'd0);
      end
      if (exp_q.size() == 0) chk("valid_when_empty", 32'(out_valid), 32'd0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 32'd1, 32'd0);
        end else begin
          chk("out_data", out_data, exp_q[0][pos*DATA_W +: DATA_W]);
          chk("out_idx", 32'(out_idx), 32'(pos));
          chk("out_last", 32'(out_last), 32'(pos == DEPTH - 1));
          run_sum = run_sum + exp_q[0][pos*DATA_W +: DATA_W];
          pos++;
          hs_cnt++;
          if (pos == DEPTH) begin
            pend_done = 1;
            exp_sum = run_sum;
            run_sum = '0;
            pos = 0;
            if (chk_bubble && exp_q.size() > 1) bubble_pend = 1;
            void'(exp_q.pop_front());
          end
        end
      end
      prev_v = out_valid; prev_r = out_ready; prev_d = out_data; prev_i = out_idx;
    end
  end

  task automatic wr(input int a, input logic [DATA_W-1:0] d);
    logic completed;
    completed = 0;
    if (a >= DEPTH) begin
      exp_addr = 1;
    end else if (exp_q.size() == 2) begin
      exp_ovf = 1;
    end else begin
      if (cur_mask[a]) exp_dup = 1;
      cur_mask[a] = 1'b1;
      cur_vec[a*DATA_W +: DATA_W] = d;
      if (&cur_mask) begin
        exp_q.push_back(cur_vec);
        cur_mask = '0;
        completed = 1;
      end
    end
    in_addr = a[ADDR_W-1:0];
    in_wr_en = 1'b1;
    in_wr_data = d;
    @(posedge clk); #1;
    in_wr_en = 1'b0;
    // The completed bank is swapped out one cycle later; give it room.
    if (completed) begin
      repeat (2) @(posedge clk);
      #1;
    end
  endtask

  task automatic fill_const(input logic [DATA_W-1:0] d);
    for (int i = 0; i < DEPTH; i++) wr(i, d);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_wr_en = 1'b0;
    cur_mask = '0;
    exp_dup = 0; exp_addr = 0; exp_ovf = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic chk_errs(input string tag);
    chk({tag, "_err_dup"}, 32'(err_dup), 32'(exp_dup));
    chk({tag, "_err_addr"}, 32'(err_addr), 32'(exp_addr));
    chk({tag, "_err_ovf"}, 32'(err_ovf), 32'(exp_ovf));
  endtask

  initial begin
    int base, n;
    int perm[DEPTH];

    rmode = 3;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_checksum", checksum, 32'd0);
    chk_errs("rst");

    // T1: reverse-order fill, always ready, latency 2
    do_reset();
    rmode = 0;
    for (int a = DEPTH - 1; a >= 1; a--) wr(a, 32'(100 + (DEPTH - 1 - a)));
    in_addr = '0; in_wr_en = 1'b1; in_wr_data = 32'd107;
    cur_vec[0 +: DATA_W] = 32'd107;
    exp_q.push_back(cur_vec);
    cur_mask = '0;
    @(posedge clk); #1;
    in_wr_en = 1'b0;
    @(negedge clk);
    chk("t1_latency_t1", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk("t1_latency_t2", 32'(out_valid), 32'd1);
    chk("t1_first_word", out_data, 32'd107);
    wait_empty();
    chk("t1_checksum", checksum, 32'd828);
    chk_errs("t1");

    // T2: same fill with toggling ready
    do_reset();
    rmode = 1;
    for (int a = DEPTH - 1; a >= 0; a--) wr(a, 32'(100 + (DEPTH - 1 - a)));
    wait_empty();
    chk("t2_checksum", checksum, 32'd828);
    chk_errs("t2");

    // T3: second vector fills while the first is stalled
    do_reset();
    rmode = 3;
    fill_const(32'd1);
    fill_const(32'd2);
    repeat (20) @(posedge clk);
    #1;
    chk("t3_ovf", 32'(err_ovf), 32'd0);
    chk_bubble = 1;
    rmode = 0;
    wait_empty();
    chk_bubble = 0;
    chk("t3_checksum", checksum, 32'd16);
    chk_errs("t3");

    // T4: write while both banks are full
    do_reset();
    rmode = 3;
    for (int i = 0; i < DEPTH; i++) wr(i, $urandom);
    for (int i = 0; i < DEPTH; i++) wr(i, $urandom);
    wr(0, 32'd5);
    @(posedge clk); #1;
    chk("t4_ovf", 32'(err_ovf), 32'd1);
    rmode = 0;
    wait_empty();
    chk_errs("t4");

    // T5: duplicate index and out-of-range address
    do_reset();
    rmode = 0;
    wr(3, 32'd9);
    wr(3, 32'd11);
    wr(8, 32'd77);
    for (int i = 0; i < DEPTH - 1; i++) if (i != 3) wr(i, 32'(20 + i));
    repeat (3) @(posedge clk);
    #1;
    chk("t5_mask_unchanged", 32'(out_valid), 32'd0);
    wr(DEPTH - 1, 32'd27);
    wait_empty();
    chk("t5_err_dup", 32'(err_dup), 32'd1);
    chk("t5_err_addr", 32'(err_addr), 32'd1);
    chk_errs("t5");

    // T6: reset after the 4th handshake
    do_reset();
    rmode = 0;
    wr(0, 32'd1);
    base = hs_cnt;
    for (int i = 0; i < DEPTH; i++) wr(i, 32'(40 + i));
    n = 0;
    while (hs_cnt < base + 4 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t6_hs_timeout", 32'(hs_cnt), 32'(base + 4));
    rst = 1'b1;
    rmode = 3;
    out_ready = 1'b0;
    cur_mask = '0;
    exp_dup = 0; exp_addr = 0; exp_ovf = 0;
    @(posedge clk); #1;
    chk("t6_valid_off", 32'(out_valid), 32'd0);
    chk("t6_no_done", 32'(done), 32'd0);
    chk_errs("t6_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    rmode = 0;
    repeat (5) @(posedge clk);
    #1;
    for (int i = 0; i < DEPTH; i++) wr(i, 32'(60 + i));
    wait_empty();
    chk_errs("t6");

    // T7: randomized fills, duplicates, bad addresses and backpressure
    do_reset();
    rmode = 2;
    for (int v = 0; v < 10; v++) begin
      for (int i = 0; i < DEPTH; i++) perm[i] = i;
      for (int i = DEPTH - 1; i > 0; i--) begin
        int j, t;
        j = $urandom_range(0, i);
        t = perm[i]; perm[i] = perm[j]; perm[j] = t;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if ($urandom_range(0, 7) == 0) wr(perm[i], $urandom);
        if ($urandom_range(0, 9) == 0) wr($urandom_range(DEPTH, 15), $urandom);
        wr(perm[i], $urandom);
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
      end
    end
    wait_empty();
    chk_errs("t7");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
